// File: rtl/mem_access_ctrl_pkg.sv
// Shared widths, transfer-size codes, FSM state codes and the sel-to-size decode
// for the MEM-stage data-memory master.
package mem_access_ctrl_pkg;

  localparam int ADDR_BUS    = 32;
  localparam int DATA_BUS    = 32;
  localparam int MEM_SEL_BUS = 4;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } mem_state_e;

  // Irregular strobe patterns fall back to a word transfer.
  function automatic logic [1:0] sel_to_size(input logic [MEM_SEL_BUS-1:0] sel);
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sel_to_size = SIZE_BYTE;
      4'b0011, 4'b1100:                   sel_to_size = SIZE_HALF;
      default:                            sel_to_size = SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// SRAM-like data bus (req/addr_ok/data_ok) between the MEM-stage master and data memory.
interface mem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    data_sram_req;
  logic                    data_sram_wr;
  logic [1:0]              data_sram_size;
  logic [ADDR_WIDTH-1:0]   data_sram_addr;
  logic [DATA_WIDTH/8-1:0] data_sram_wstrb;
  logic [DATA_WIDTH-1:0]   data_sram_wdata;
  logic                    data_sram_addr_ok;
  logic                    data_sram_data_ok;
  logic [DATA_WIDTH-1:0]   data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/mem_access_ctrl_load_align.sv
// Selects the load lane from the strobes and sign/zero-extends bytes and halfwords.
module mem_access_ctrl_load_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [MEM_SEL_BUS-1:0] sel,
  input  logic                   sign_ext,
  input  logic [DATA_BUS-1:0]    rdata,
  output logic [DATA_BUS-1:0]    load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = sel[3] ? rdata[31:24] :
                sel[2] ? rdata[23:16] :
                sel[1] ? rdata[15:8]  : rdata[7:0];
    half_lane = sel[2] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (sel_to_size(sel))
      SIZE_BYTE: load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      SIZE_HALF: load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
      default:   load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory master: one outstanding SRAM-like transaction, stalls until data_ok.
// Define MEM_ADDR_CHECK_EN to reject misaligned half/word accesses with mem_addr_error_out.
//
// state | meaning
// IDLE  | no transaction; req driven combinationally when an access is present
// REQ   | request issued, waiting for addr_ok
// WAIT  | address accepted, waiting for data_ok
// DONE  | response captured; result presented until the pipe advances
// DRAIN | flushed with a transaction in flight; swallow its data_ok
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_BUS,
  parameter int DATA_WIDTH = DATA_BUS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   stall_current_stage,
  input  logic                   mem_read_flag_in,
  input  logic                   mem_write_flag_in,
  input  logic                   mem_sign_ext_flag_in,
  input  logic [MEM_SEL_BUS-1:0] mem_sel_in,
  input  logic [DATA_WIDTH-1:0]  mem_write_data_in,
  input  logic [ADDR_WIDTH-1:0]  address_in,
  mem_access_ctrl_if.master      bus,
  output logic [DATA_WIDTH-1:0]  load_data_out,
  output logic                   mem_stall_request,
  output logic                   mem_addr_error_out
);

  mem_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] aligned;
  logic [1:0]            size;
  logic                  pending, misaligned, access, req;

  assign size    = sel_to_size(mem_sel_in);
  assign pending = (mem_read_flag_in | mem_write_flag_in) & ~flush;

`ifdef MEM_ADDR_CHECK_EN
  assign misaligned = ((size == SIZE_HALF) && address_in[0]) ||
                      ((size == SIZE_WORD) && (address_in[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign access = pending & ~misaligned;

  always_comb begin
    state_d            = state_q;
    rdata_d            = rdata_q;
    req                = 1'b0;
    mem_stall_request  = 1'b0;
    mem_addr_error_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req                = access;
        mem_stall_request  = access;
        mem_addr_error_out = pending & misaligned;
        if (access) state_d = bus.data_sram_addr_ok ? ST_WAIT : ST_REQ;
      end
      ST_REQ: begin
        req               = 1'b1;
        mem_stall_request = 1'b1;
        if (bus.data_sram_addr_ok) state_d = flush ? ST_DRAIN : ST_WAIT;
        else if (flush)            state_d = ST_IDLE;
      end
      ST_WAIT: begin
        mem_stall_request = 1'b1;
        if (bus.data_sram_data_ok) begin
          rdata_d = bus.data_sram_rdata;
          state_d = flush ? ST_IDLE : ST_DONE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      // Held while a later stage stalls so the same instruction is not reissued.
      ST_DONE: begin
        if (!stall_current_stage || flush) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        mem_stall_request = pending;
        if (bus.data_sram_data_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rst) begin
      req                = 1'b0;
      mem_stall_request  = 1'b0;
      mem_addr_error_out = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  mem_access_ctrl_load_align u_load_align (
    .sel       (mem_sel_in),
    .sign_ext  (mem_sign_ext_flag_in),
    .rdata     (rdata_q),
    .load_data (aligned)
  );

  assign bus.data_sram_req   = req;
  assign bus.data_sram_wr    = req & mem_write_flag_in;
  assign bus.data_sram_size  = req ? size : 2'b00;
  assign bus.data_sram_addr  = req ? address_in : '0;
  assign bus.data_sram_wstrb = (req & mem_write_flag_in) ? mem_sel_in : '0;
  assign bus.data_sram_wdata = (req & mem_write_flag_in) ? mem_write_data_in : '0;

  assign load_data_out = (rst && state_q == ST_DONE && mem_read_flag_in) ? aligned : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, stores, flush/drain, held DONE, alignment.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, stall_current_stage;
  logic        mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] mem_write_data_in, address_in, load_data_out;
  logic        mem_stall_request, mem_addr_error_out;

  int vectors = 0;
  int miscompares = 0;

  int          r_stall, r_reqs;
  logic        r_wr, r_err, r_done;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr, r_wdata, r_ld;

  mem_access_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

  mem_access_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .stall_current_stage  (stall_current_stage),
    .mem_read_flag_in     (mem_read_flag_in),
    .mem_write_flag_in    (mem_write_flag_in),
    .mem_sign_ext_flag_in (mem_sign_ext_flag_in),
    .mem_sel_in           (mem_sel_in),
    .mem_write_data_in    (mem_write_data_in),
    .address_in           (address_in),
    .bus                  (bus_if),
    .load_data_out        (load_data_out),
    .mem_stall_request    (mem_stall_request),
    .mem_addr_error_out   (mem_addr_error_out)
  );

  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic sx, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wdata);
    mem_read_flag_in     = rd;
    mem_write_flag_in    = wr;
    mem_sign_ext_flag_in = sx;
    mem_sel_in           = sel;
    address_in           = addr;
    mem_write_data_in    = wdata;
  endtask

  // Runs one access from the current cycle until stall drops (bounded), recording what was seen.
  task automatic run_access(input int ok_at, input int data_at, input logic [31:0] rdata_v);
    r_stall = 0; r_reqs = 0; r_wr = 0; r_err = 0; r_done = 0;
    r_size = 0; r_wstrb = 0; r_addr = 0; r_wdata = 0; r_ld = 0;
    for (int c = 0; c < 30; c++) begin
      bus_if.data_sram_addr_ok = (c == ok_at);
      bus_if.data_sram_data_ok = (c == data_at);
      bus_if.data_sram_rdata   = (c == data_at) ? rdata_v : 32'h0;
      @(negedge clk);
      r_err = r_err | mem_addr_error_out;
      if (bus_if.data_sram_req) begin
        r_reqs++;
        r_wr = bus_if.data_sram_wr; r_size = bus_if.data_sram_size;
        r_addr = bus_if.data_sram_addr; r_wstrb = bus_if.data_sram_wstrb;
        r_wdata = bus_if.data_sram_wdata;
      end
      if (!mem_stall_request) begin
        r_ld = load_data_out; r_done = 1;
        break;
      end
      r_stall++;
      next_cycle();
    end
    bus_if.data_sram_addr_ok = 0;
    bus_if.data_sram_data_ok = 0;
    vectors++;
    if (r_done !== 1'b1) begin miscompares++; $display("FAIL access_timeout: got stall_cycles %0d, required completion", r_stall); end
  endtask

  task automatic end_access;
    next_cycle();
    set_op(0, 0, 0, 4'b0000, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    rst = 0;
    set_op(1, 0, 0, 4'b1111, 32'h100, 32'h0);
    bus_if.data_sram_addr_ok = 1;
    @(negedge clk);
    vectors++; if (bus_if.data_sram_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", bus_if.data_sram_req); end
    vectors++; if (mem_stall_request !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", mem_stall_request); end
    vectors++; if (load_data_out !== 32'h0) begin miscompares++; $display("FAIL reset_ld: got %h expected 0", load_data_out); end
    vectors++; if (bus_if.data_sram_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", bus_if.data_sram_addr); end
    next_cycle();
    next_cycle();
    rst = 1;
    set_op(0, 0, 0, 4'b0000, 32'h0, 32'h0);
    bus_if.data_sram_addr_ok = 0;
    @(negedge clk);
    vectors++; if (mem_stall_request !== 1'b0 || bus_if.data_sram_req !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle: got stall %b req %b expected 0 0", mem_stall_request, bus_if.data_sram_req); end
    next_cycle();
  endtask

  task automatic test_lw;
    set_op(1, 0, 0, 4'b1111, 32'h100, 32'h0);
    run_access(0, 3, 32'hCAFEF00D);
    vectors++; if (r_stall !== 4) begin miscompares++; $display("FAIL lw_stall: got %0d expected 4", r_stall); end
    vectors++; if (r_reqs !== 1) begin miscompares++; $display("FAIL lw_reqs: got %0d expected 1", r_reqs); end
    vectors++; if (r_wr !== 1'b0 || r_size !== 2'd2 || r_wstrb !== 4'b0000) begin miscompares++; $display("FAIL lw_payload: got wr %b size %0d wstrb %b expected 0 2 0000", r_wr, r_size, r_wstrb); end
    vectors++; if (r_addr !== 32'h100) begin miscompares++; $display("FAIL lw_addr: got %h expected 00000100", r_addr); end
    vectors++; if (r_ld !== 32'hCAFEF00D) begin miscompares++; $display("FAIL lw_data: got %h expected cafef00d", r_ld); end
    end_access();
  endtask

  task automatic test_load_extend;
    logic [3:0]  sel_t [5] = '{4'b0100, 4'b0100, 4'b0011, 4'b1100, 4'b1000};
    logic        sx_t  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] rd_t  [5] = '{32'h00800000, 32'h00800000, 32'h12348001, 32'h80011234, 32'hF0000000};
    logic [31:0] exp_t [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'hFFFFFFF0};
    logic [1:0]  sz_t  [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
    for (int i = 0; i < 5; i++) begin
      set_op(1, 0, sx_t[i], sel_t[i], 32'h200, 32'h0);
      run_access(0, 1, rd_t[i]);
      vectors++; if (r_ld !== exp_t[i]) begin miscompares++; $display("FAIL ext_data[%0d]: got %h expected %h", i, r_ld, exp_t[i]); end
      vectors++; if (r_size !== sz_t[i] || r_stall !== 2) begin miscompares++; $display("FAIL ext_size[%0d]: got size %0d stall %0d expected %0d 2", i, r_size, r_stall, sz_t[i]); end
      end_access();
    end
  endtask

  task automatic test_sh;
    set_op(0, 1, 0, 4'b1100, 32'h202, 32'hBEEFBEEF);
    run_access(2, 4, 32'h0);
    vectors++; if (r_reqs !== 3 || r_stall !== 5) begin miscompares++; $display("FAIL sh_timing: got reqs %0d stall %0d expected 3 5", r_reqs, r_stall); end
    vectors++; if (r_wr !== 1'b1 || r_size !== 2'd1 || r_wstrb !== 4'b1100) begin miscompares++; $display("FAIL sh_ctrl: got wr %b size %0d wstrb %b expected 1 1 1100", r_wr, r_size, r_wstrb); end
    vectors++; if (r_wdata !== 32'hBEEFBEEF || r_addr !== 32'h202) begin miscompares++; $display("FAIL sh_data: got wdata %h addr %h expected beefbeef 00000202", r_wdata, r_addr); end
    vectors++; if (r_ld !== 32'h0) begin miscompares++; $display("FAIL sh_ld: got %h expected 0", r_ld); end
    end_access();
  endtask

  task automatic test_flush;
    // flush while waiting for data: stale data_ok must be swallowed
    set_op(1, 0, 0, 4'b1111, 32'h100, 32'h0);
    bus_if.data_sram_addr_ok = 1;
    next_cycle();
    bus_if.data_sram_addr_ok = 0;
    flush = 1;
    next_cycle();
    flush = 0;
    set_op(1, 0, 0, 4'b1111, 32'h300, 32'h0);
    @(negedge clk);
    vectors++; if (bus_if.data_sram_req !== 1'b0 || mem_stall_request !== 1'b1) begin miscompares++; $display("FAIL drain_hold: got req %b stall %b expected 0 1", bus_if.data_sram_req, mem_stall_request); end
    next_cycle();
    bus_if.data_sram_data_ok = 1;
    bus_if.data_sram_rdata = 32'hDEADDEAD;
    @(negedge clk);
    vectors++; if (bus_if.data_sram_req !== 1'b0) begin miscompares++; $display("FAIL drain_noreq: got %b expected 0", bus_if.data_sram_req); end
    next_cycle();
    run_access(0, 2, 32'h0BADCAFE);
    vectors++; if (r_ld !== 32'h0BADCAFE || r_stall !== 3 || r_addr !== 32'h300) begin miscompares++; $display("FAIL post_drain_lw: got data %h stall %0d addr %h expected 0badcafe 3 00000300", r_ld, r_stall, r_addr); end
    end_access();
    // flush in REQ before addr_ok: nothing outstanding, straight back to IDLE
    set_op(1, 0, 0, 4'b1111, 32'h400, 32'h0);
    next_cycle();
    flush = 1;
    @(negedge clk);
    vectors++; if (bus_if.data_sram_req !== 1'b1) begin miscompares++; $display("FAIL req_held_flush: got %b expected 1", bus_if.data_sram_req); end
    next_cycle();
    flush = 0;
    run_access(0, 1, 32'h13572468);
    vectors++; if (r_reqs !== 1 || r_stall !== 2 || r_ld !== 32'h13572468) begin miscompares++; $display("FAIL req_flush_idle: got reqs %0d stall %0d data %h expected 1 2 13572468", r_reqs, r_stall, r_ld); end
    end_access();
    // addr_ok together with flush in REQ: transaction in flight, must drain
    set_op(1, 0, 0, 4'b1111, 32'h500, 32'h0);
    next_cycle();
    flush = 1;
    bus_if.data_sram_addr_ok = 1;
    next_cycle();
    flush = 0;
    bus_if.data_sram_addr_ok = 0;
    @(negedge clk);
    vectors++; if (bus_if.data_sram_req !== 1'b0 || mem_stall_request !== 1'b1) begin miscompares++; $display("FAIL req_ok_flush_drain: got req %b stall %b expected 0 1", bus_if.data_sram_req, mem_stall_request); end
    next_cycle();
    bus_if.data_sram_data_ok = 1;
    next_cycle();
    bus_if.data_sram_data_ok = 0;
    set_op(0, 0, 0, 4'b0000, 32'h0, 32'h0);
    next_cycle();
  endtask

  task automatic test_held_done;
    int extra_reqs = 0;
    int bad = 0;
    stall_current_stage = 1;
    set_op(1, 0, 0, 4'b1111, 32'h600, 32'h0);
    run_access(0, 1, 32'h55AA33CC);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      if (bus_if.data_sram_req) extra_reqs++;
      if (mem_stall_request !== 1'b0 || load_data_out !== 32'h55AA33CC) bad++;
    end
    vectors++; if (r_reqs + extra_reqs !== 1) begin miscompares++; $display("FAIL held_reqs: got %0d expected 1", r_reqs + extra_reqs); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL held_output: got %0d bad cycles expected 0", bad); end
    next_cycle();
    stall_current_stage = 0;
    @(negedge clk);
    vectors++; if (load_data_out !== 32'h55AA33CC || bus_if.data_sram_req !== 1'b0) begin miscompares++; $display("FAIL held_release: got data %h req %b expected 55aa33cc 0", load_data_out, bus_if.data_sram_req); end
    end_access();
  endtask

  task automatic test_misaligned;
    set_op(1, 0, 0, 4'b1111, 32'h102, 32'h0);
`ifdef MEM_ADDR_CHECK_EN
    @(negedge clk);
    vectors++; if (mem_addr_error_out !== 1'b1 || bus_if.data_sram_req !== 1'b0 || mem_stall_request !== 1'b0) begin miscompares++; $display("FAIL misaligned_check: got err %b req %b stall %b expected 1 0 0", mem_addr_error_out, bus_if.data_sram_req, mem_stall_request); end
    end_access();
`else
    run_access(0, 1, 32'h11112222);
    vectors++; if (r_err !== 1'b0 || r_addr !== 32'h102 || r_ld !== 32'h11112222) begin miscompares++; $display("FAIL misaligned_pass: got err %b addr %h data %h expected 0 00000102 11112222", r_err, r_addr, r_ld); end
    end_access();
`endif
  endtask

  task automatic test_back_to_back;
    set_op(0, 1, 0, 4'b0001, 32'h401, 32'h000000AA);
    run_access(1, 2, 32'h0);
    vectors++; if (r_stall !== 3 || r_reqs !== 2 || r_size !== 2'd0 || r_wstrb !== 4'b0001 || r_wdata !== 32'hAA) begin miscompares++; $display("FAIL b2b_sb: got stall %0d reqs %0d size %0d wstrb %b wdata %h expected 3 2 0 0001 000000aa", r_stall, r_reqs, r_size, r_wstrb, r_wdata); end
    next_cycle();
    set_op(1, 0, 0, 4'b1111, 32'h404, 32'h0);
    run_access(0, 1, 32'h89ABCDEF);
    vectors++; if (r_stall !== 2 || r_ld !== 32'h89ABCDEF || r_addr !== 32'h404) begin miscompares++; $display("FAIL b2b_lw: got stall %0d data %h addr %h expected 2 89abcdef 00000404", r_stall, r_ld, r_addr); end
    end_access();
  endtask

  initial begin
    rst = 0; flush = 0; stall_current_stage = 0;
    set_op(0, 0, 0, 4'b0000, 32'h0, 32'h0);
    bus_if.data_sram_addr_ok = 0;
    bus_if.data_sram_data_ok = 0;
    bus_if.data_sram_rdata = 32'h0;
    #1;
    test_reset();
    test_lw();
    test_load_extend();
    test_sh();
    test_flush();
    test_held_done();
    test_misaligned();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
